// File: rtl/fetch_pipe_ctrl.sv
// rtl/fetch_pipe_ctrl.sv - PC and IF/ID register owner applying stall, flush and HLT freeze
module fetch_pipe_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             if_flush,
    input  logic [15:0]      br_target,
    input  logic [15:0]      imem_data,
    output logic [15:0]      imem_addr,
    output logic [15:0]      if_id_inst,
    output logic [15:0]      if_id_pc_plus2,
    output logic             if_id_valid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_HALT_PEND = 2'b01,
        ST_HALTED    = 2'b10,
        ST_BAD       = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       HLT_OP  = 4'b1111;

    state_t           r_state;
    logic [15:0]      r_pc;
    logic [15:0]      r_inst;
    logic [15:0]      r_pc_plus2;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    state_t           w_state_next;
    logic [15:0]      w_pc_next;
    logic [15:0]      w_inst_next;
    logic [15:0]      w_pc_plus2_next;
    logic             w_valid_next;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic [15:0]      w_pc_inc;
    logic             w_is_hlt;

    assign w_pc_inc = r_pc + 16'd2;
    assign w_is_hlt = (imem_data[15:12] == HLT_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_inst      <= NOP_INST;
            r_pc_plus2  <= 16'h0000;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_inst     <= w_inst_next;
            r_pc_plus2 <= w_pc_plus2_next;
            r_valid    <= w_valid_next;
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    // Flush outranks everything, including the HALTED freeze and a concurrent stall.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_inst_next     = r_inst;
        w_pc_plus2_next = r_pc_plus2;
        w_valid_next    = r_valid;
        w_stall_inc     = 1'b0;
        w_flush_inc     = 1'b0;

        if (if_flush) begin
            w_pc_next       = br_target;
            w_inst_next     = NOP_INST;
            w_pc_plus2_next = 16'h0000;
            w_valid_next    = 1'b0;
            w_state_next    = ST_RUN;
            w_flush_inc     = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (stall) begin
                        w_stall_inc = 1'b1;
                    end else begin
                        w_inst_next     = imem_data;
                        w_pc_plus2_next = w_pc_inc;
                        w_valid_next    = 1'b1;
                        if (w_is_hlt) begin
                            w_state_next = ST_HALT_PEND;
                        end else begin
                            w_pc_next = w_pc_inc;
                        end
                    end
                end
                ST_HALT_PEND: begin
                    if (stall) begin
                        w_stall_inc = 1'b1;
                    end else begin
                        w_inst_next     = NOP_INST;
                        w_pc_plus2_next = 16'h0000;
                        w_valid_next    = 1'b0;
                        w_state_next    = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    w_inst_next  = NOP_INST;
                    w_valid_next = 1'b0;
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    assign imem_addr      = r_pc;
    assign if_id_inst     = r_inst;
    assign if_id_pc_plus2 = r_pc_plus2;
    assign if_id_valid    = r_valid;
    assign halted         = (r_state == ST_HALTED);
    assign stall_cnt      = r_stall_cnt;
    assign flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// tb/tb_fetch_pipe_ctrl.sv - vector table, corner sequences and random model check for fetch_pipe_ctrl
module tb_fetch_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        if_flush;
    logic [15:0] br_target;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        stall2;
    logic [15:0] imem_addr2;
    logic [15:0] if_id_inst2;
    logic [15:0] if_id_pc_plus22;
    logic        if_id_valid2;
    logic        halted2;
    logic [1:0]  stall_cnt2;
    logic [1:0]  flush_cnt2;

    logic        tbl_mode;
    logic [15:0] tbl_inst;
    logic [15:0] mem [256];

    int n_cmp;
    int n_fail;

    fetch_pipe_ctrl #(.RESET_PC(16'h0000), .NOP_INST(16'h0000), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .if_flush(if_flush),
        .br_target(br_target), .imem_data(imem_data), .imem_addr(imem_addr),
        .if_id_inst(if_id_inst), .if_id_pc_plus2(if_id_pc_plus2),
        .if_id_valid(if_id_valid), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fetch_pipe_ctrl #(.RESET_PC(16'h0000), .NOP_INST(16'h0000), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall2), .if_flush(1'b0),
        .br_target(16'h0000), .imem_data(16'h1000), .imem_addr(imem_addr2),
        .if_id_inst(if_id_inst2), .if_id_pc_plus2(if_id_pc_plus22),
        .if_id_valid(if_id_valid2), .halted(halted2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_data = tbl_mode ? tbl_inst : mem[imem_addr[8:1]];
    end

    typedef struct {
        logic        stall;
        logic        flush;
        logic [15:0] tgt;
        logic [15:0] inst;
        logic [15:0] e_addr;
        logic [15:0] e_inst;
        logic [15:0] e_pp2;
        logic        e_valid;
        logic        e_halted;
        int          e_sc;
        int          e_fc;
    } vec_t;

    vec_t tv [21];

    function automatic vec_t mk(input logic s, input logic f, input logic [15:0] t,
                                input logic [15:0] i, input logic [15:0] a,
                                input logic [15:0] ei, input logic [15:0] ep,
                                input logic ev, input logic eh, input int sc, input int fc);
        vec_t v;
        v.stall = s; v.flush = f; v.tgt = t; v.inst = i;
        v.e_addr = a; v.e_inst = ei; v.e_pp2 = ep; v.e_valid = ev; v.e_halted = eh;
        v.e_sc = sc; v.e_fc = fc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the fetch unit as a PC plus a one-slot IF/ID buffer and two halt flags.
    logic [15:0] m_pc, m_inst, m_pp2;
    logic        m_valid, m_hlt_pend, m_halted;
    int          m_sc, m_fc;

    task automatic model_reset();
        m_pc = 16'h0000; m_inst = 16'h0000; m_pp2 = 16'h0000;
        m_valid = 1'b0; m_hlt_pend = 1'b0; m_halted = 1'b0; m_sc = 0; m_fc = 0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic [15:0] t);
        logic [15:0] word;
        word = mem[m_pc[8:1]];
        if (f) begin
            m_pc = t; m_inst = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0;
            m_hlt_pend = 1'b0; m_halted = 1'b0;
            if (m_fc < 65535) m_fc++;
        end else if (m_halted) begin
            m_inst = 16'h0000; m_valid = 1'b0;
        end else if (s) begin
            if (m_sc < 65535) m_sc++;
        end else if (m_hlt_pend) begin
            m_inst = 16'h0000; m_valid = 1'b0; m_hlt_pend = 1'b0; m_halted = 1'b1;
        end else begin
            m_inst = word; m_pp2 = m_pc + 16'd2; m_valid = 1'b1;
            if (word[15:12] == 4'hF) m_hlt_pend = 1'b1;
            else m_pc = m_pc + 16'd2;
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; stall = 1'b0; if_flush = 1'b0; br_target = 16'h0000;
        stall2 = 1'b0; tbl_mode = 1'b1; tbl_inst = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        tv[0]  = mk(0, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0, 0, 0);
        tv[1]  = mk(0, 0, 16'h0000, 16'h2345, 16'h0004, 16'h2345, 16'h0004, 1, 0, 0, 0);
        tv[2]  = mk(0, 0, 16'h0000, 16'h3000, 16'h0006, 16'h3000, 16'h0006, 1, 0, 0, 0);
        tv[3]  = mk(1, 0, 16'h0000, 16'h4444, 16'h0006, 16'h3000, 16'h0006, 1, 0, 1, 0);
        tv[4]  = mk(1, 0, 16'h0000, 16'h4444, 16'h0006, 16'h3000, 16'h0006, 1, 0, 2, 0);
        tv[5]  = mk(1, 0, 16'h0000, 16'h4444, 16'h0006, 16'h3000, 16'h0006, 1, 0, 3, 0);
        tv[6]  = mk(1, 1, 16'h0040, 16'h4444, 16'h0040, 16'h0000, 16'h0000, 0, 0, 3, 1);
        tv[7]  = mk(0, 0, 16'h0000, 16'h1111, 16'h0042, 16'h1111, 16'h0042, 1, 0, 3, 1);
        tv[8]  = mk(0, 1, 16'h0010, 16'h1111, 16'h0010, 16'h0000, 16'h0000, 0, 0, 3, 2);
        tv[9]  = mk(0, 0, 16'h0000, 16'hF000, 16'h0010, 16'hF000, 16'h0012, 1, 0, 3, 2);
        tv[10] = mk(0, 0, 16'h0000, 16'h5555, 16'h0010, 16'h0000, 16'h0000, 0, 1, 3, 2);
        tv[11] = mk(1, 0, 16'h0000, 16'h5555, 16'h0010, 16'h0000, 16'h0000, 0, 1, 3, 2);
        tv[12] = mk(0, 1, 16'h0030, 16'h5555, 16'h0030, 16'h0000, 16'h0000, 0, 0, 3, 3);
        tv[13] = mk(0, 0, 16'h0000, 16'hF123, 16'h0030, 16'hF123, 16'h0032, 1, 0, 3, 3);
        tv[14] = mk(0, 1, 16'h0020, 16'h6666, 16'h0020, 16'h0000, 16'h0000, 0, 0, 3, 4);
        tv[15] = mk(0, 0, 16'h0000, 16'h0777, 16'h0022, 16'h0777, 16'h0022, 1, 0, 3, 4);
        tv[16] = mk(0, 1, 16'hFFFE, 16'h0777, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 3, 5);
        tv[17] = mk(0, 0, 16'h0000, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 1, 0, 3, 5);
        tv[18] = mk(0, 0, 16'h0000, 16'hF000, 16'h0000, 16'hF000, 16'h0002, 1, 0, 3, 5);
        tv[19] = mk(1, 0, 16'h0000, 16'h2222, 16'h0000, 16'hF000, 16'h0002, 1, 0, 4, 5);
        tv[20] = mk(0, 0, 16'h0000, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 0, 1, 4, 5);

        repeat (2) @(negedge clk);
        chk("reset_addr", imem_addr, 16'h0000);
        chk("reset_inst", if_id_inst, 16'h0000);
        chk("reset_pp2", if_id_pc_plus2, 16'h0000);
        chk("reset_valid", if_id_valid, 1'b0);
        chk("reset_halted", halted, 1'b0);
        chk("reset_scnt", stall_cnt, 16'd0);
        chk("reset_fcnt", flush_cnt, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            stall = tv[i].stall; if_flush = tv[i].flush;
            br_target = tv[i].tgt; tbl_inst = tv[i].inst;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].e_addr);
            chk($sformatf("tv%0d_inst", i), if_id_inst, tv[i].e_inst);
            if (tv[i].e_valid) chk($sformatf("tv%0d_pp2", i), if_id_pc_plus2, tv[i].e_pp2);
            chk($sformatf("tv%0d_valid", i), if_id_valid, tv[i].e_valid);
            chk($sformatf("tv%0d_halted", i), halted, tv[i].e_halted);
            chk($sformatf("tv%0d_scnt", i), stall_cnt, tv[i].e_sc[15:0]);
            chk($sformatf("tv%0d_fcnt", i), flush_cnt, tv[i].e_fc[15:0]);
        end

        // HALTED must hold through stalls and any fetched word.
        if_flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom_range(1));
            tbl_inst = (i % 2 == 0) ? 16'hF000 : 16'h1357;
            @(posedge clk);
            @(negedge clk);
            chk("halt_hold_addr", imem_addr, 16'h0000);
            chk("halt_hold_halted", halted, 1'b1);
            chk("halt_hold_valid", if_id_valid, 1'b0);
            chk("halt_hold_scnt", stall_cnt, 16'd4);
        end

        stall = 1'b0; if_flush = 1'b1; br_target = 16'h0050;
        @(posedge clk);
        @(negedge clk);
        chk("flush_pp2_zero", if_id_pc_plus2, 16'h0000);
        chk("flush_fcnt", flush_cnt, 16'd6);
        chk("flush_unhalt", halted, 1'b0);
        if_flush = 1'b0; stall = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_addr", imem_addr, 16'h0000);
        chk("async_rst_valid", if_id_valid, 1'b0);
        chk("async_rst_scnt", stall_cnt, 16'd0);
        chk("async_rst_fcnt", flush_cnt, 16'd0);
        chk("async_rst_inst", if_id_inst, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;

        stall2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("cnt2_three", stall_cnt2, 2'd3);
        repeat (2) @(negedge clk);
        chk("cnt2_saturate", stall_cnt2, 2'd3);
        chk("cnt2_fcnt", flush_cnt2, 2'd0);
        stall2 = 1'b0;

        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(7) == 0) w[15:12] = 4'hF;
            mem[i] = w;
        end
        tbl_mode = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            stall = ($urandom_range(4) == 0);
            if_flush = ($urandom_range(9) == 0);
            br_target = 16'($urandom);
            @(posedge clk);
            model_edge(stall, if_flush, br_target);
            @(negedge clk);
            chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_inst", if_id_inst, m_inst);
            chk("rnd_valid", if_id_valid, m_valid);
            if (m_valid) chk("rnd_pp2", if_id_pc_plus2, m_pp2);
            chk("rnd_halted", halted, m_halted);
            chk("rnd_scnt", stall_cnt, m_sc[15:0]);
            chk("rnd_fcnt", flush_cnt, m_fc[15:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
